qoa_mc_lms_decoder: RTL and testbench

Multi-channel, parametrised QOA sample decoder. It parses a byte command stream carrying per-channel LMS state loads, channel resets and encoded residuals (scalefactor + quantised residual). For each residual it runs the LMS predict/dequantise/clamp/update loop on a single shared multiply-accumulate unit, then pushes the decoded sample, tagged with its channel, into an output FIFO. It sits between the SPI byte deserialiser and the audio output or SPI readback path.

---
 rtl/qoa_pkg.sv | 63 ++++++
 rtl/qoa_sample_fifo.sv | 52 +++++
 rtl/qoa_mc_lms_decoder.sv | 191 +++++++++++++++++++
 tb/tb_qoa_mc_lms_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qoa_pkg.sv
// rtl/qoa_pkg.sv - shared encodings, dequantisation table and clamp for the QOA LMS decoder
package qoa_pkg;

  localparam int LMS_SHIFT = 13;

  typedef enum logic [1:0] {
    OP_LOAD_HIST = 2'b00,
    OP_LOAD_WGT  = 2'b01,
    OP_DECODE    = 2'b10,
    OP_RESET_CH  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAY_HI,
    ST_PAY_LO,
    ST_DEC_PAY,
    ST_MAC,
    ST_UPDATE
  } state_e;

  function automatic logic [11:0] sf_tab(input logic [3:0] sf);
    case (sf)
      4'd0:    return 12'd1;
      4'd1:    return 12'd7;
      4'd2:    return 12'd21;
      4'd3:    return 12'd45;
      4'd4:    return 12'd84;
      4'd5:    return 12'd138;
      4'd6:    return 12'd211;
      4'd7:    return 12'd304;
      4'd8:    return 12'd421;
      4'd9:    return 12'd562;
      4'd10:   return 12'd731;
      4'd11:   return 12'd928;
      4'd12:   return 12'd1157;
      4'd13:   return 12'd1419;
      4'd14:   return 12'd1715;
      default: return 12'd2048;
    endcase
  endfunction

  // DEQ_TAB[sf][qr]: Q magnitudes held as quarters (0.75,2.5,4.5,7 -> 3,10,18,28); +2 then >>2 rounds half away
  function automatic logic signed [15:0] deq_tab(input logic [3:0] sf, input logic [2:0] qr);
    logic [4:0]  m;
    logic [15:0] mag;
    case (qr[2:1])
      2'd0:    m = 5'd3;
      2'd1:    m = 5'd10;
      2'd2:    m = 5'd18;
      default: m = 5'd28;
    endcase
    mag = 16'((17'(sf_tab(sf)) * 17'(m) + 17'd2) >> 2);
    return qr[0] ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic signed [15:0] clamp16(input logic signed [47:0] v);
    if (v > 48'sd32767)       return 16'sh7fff;
    else if (v < -48'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

endpackage

// File: rtl/qoa_sample_fifo.sv
// rtl/qoa_sample_fifo.sv - decoded sample FIFO holding {ch, sample} words
module qoa_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && (r_count != CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  assign valid = (r_count != '0);
  assign dout  = valid ? r_mem[r_rd] : '0;
  assign count = r_count;

endmodule

// File: rtl/qoa_mc_lms_decoder.sv
// rtl/qoa_mc_lms_decoder.sv - multi-channel QOA LMS decoder with shared MAC and output FIFO
module qoa_mc_lms_decoder
  import qoa_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int LMS_LEN    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W      = 36
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sample,
  output logic [2:0]  out_ch,
  output logic        busy,
  output logic        err
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TAP_W = (LMS_LEN > 1) ? $clog2(LMS_LEN) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]       NUM_CH_L  = 4'(NUM_CH);
  localparam logic [3:0]       LMS_LEN_L = 4'(LMS_LEN);
  localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(LMS_LEN - 1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic signed [15:0]      r_hist [NUM_CH][LMS_LEN];
  logic signed [15:0]      r_wgt  [NUM_CH][LMS_LEN];
  logic signed [ACC_W-1:0] r_acc;
  logic [TAP_W-1:0]        r_tap;
  op_e                     r_op;
  logic [TAP_W-1:0]        r_idx;
  logic [2:0]              r_ch;
  logic                    r_bad;
  logic                    r_err;
  logic [7:0]              r_hi;
  logic signed [15:0]      r_deq;

  op_e                     w_hdr_op;
  logic                    w_hdr_bad;
  logic                    w_in_ready;
  logic                    w_accept;
  logic [CH_W-1:0]         w_ci;
  logic signed [31:0]      w_prod;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [15:0]      w_sample;
  logic signed [15:0]      w_delta;
  logic                    w_push;
  logic                    w_fifo_valid;
  logic [CNT_W-1:0]        w_count;
  logic [18:0]             w_fifo_dout;

  assign w_hdr_op  = op_e'(in_byte[7:6]);
  assign w_hdr_bad = ({1'b0, in_byte[2:0]} >= NUM_CH_L) ||
                     (!in_byte[7] && ({1'b0, in_byte[5:3]} >= LMS_LEN_L));
  assign w_ci      = r_ch[CH_W-1:0];
  assign w_accept  = in_valid && w_in_ready;
  assign w_prod    = r_hist[w_ci][r_tap] * r_wgt[w_ci][r_tap];
  assign w_sum     = (r_acc >>> LMS_SHIFT) + ACC_W'(r_deq);
  assign w_sample  = clamp16(48'(w_sum));
  assign w_delta   = r_deq >>> 4;
  assign w_push    = (r_state == ST_UPDATE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          case (w_hdr_op)
            OP_LOAD_HIST, OP_LOAD_WGT: w_state_nxt = ST_PAY_HI;
            OP_DECODE:                 w_state_nxt = ST_DEC_PAY;
            default:                   w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_PAY_HI: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_PAY_LO;
      end
      ST_PAY_LO: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_IDLE;
      end
      // a pop in this same cycle is deliberately not credited as free space
      ST_DEC_PAY: begin
        w_in_ready = (w_count < CNT_W'(FIFO_DEPTH));
        if (in_valid && w_in_ready) w_state_nxt = r_bad ? ST_IDLE : ST_MAC;
      end
      ST_MAC:    if (r_tap == LAST_TAP) w_state_nxt = ST_UPDATE;
      ST_UPDATE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < LMS_LEN; t++) begin
          r_hist[c][t] <= '0;
          r_wgt[c][t]  <= '0;
        end
      end
      r_acc <= '0;
      r_tap <= '0;
      r_op  <= OP_LOAD_HIST;
      r_idx <= '0;
      r_ch  <= '0;
      r_bad <= 1'b0;
      r_err <= 1'b0;
      r_hi  <= '0;
      r_deq <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_op  <= w_hdr_op;
          r_idx <= in_byte[3 +: TAP_W];
          r_ch  <= in_byte[2:0];
          r_bad <= w_hdr_bad;
          if (w_hdr_op == OP_RESET_CH) begin
            if (w_hdr_bad) r_err <= 1'b1;
            else begin
              for (int t = 0; t < LMS_LEN; t++) begin
                r_hist[in_byte[CH_W-1:0]][t] <= '0;
                r_wgt[in_byte[CH_W-1:0]][t]  <= '0;
              end
            end
          end
        end
        ST_PAY_HI: if (in_valid) r_hi <= in_byte;
        ST_PAY_LO: if (in_valid) begin
          if (r_bad)                      r_err <= 1'b1;
          else if (r_op == OP_LOAD_HIST)  r_hist[w_ci][r_idx] <= {r_hi, in_byte};
          else                            r_wgt[w_ci][r_idx]  <= {r_hi, in_byte};
        end
        ST_DEC_PAY: if (w_accept) begin
          r_err <= r_bad;
          r_deq <= deq_tab(in_byte[7:4], in_byte[3:1]);
          r_acc <= '0;
          r_tap <= '0;
        end
        ST_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_tap <= r_tap + TAP_W'(1);
        end
        ST_UPDATE: begin
          for (int t = 0; t < LMS_LEN; t++)
            r_wgt[w_ci][t] <= r_wgt[w_ci][t] + (r_hist[w_ci][t][15] ? -w_delta : w_delta);
          for (int t = 0; t < LMS_LEN - 1; t++)
            r_hist[w_ci][t] <= r_hist[w_ci][t+1];
          r_hist[w_ci][LMS_LEN-1] <= w_sample;
        end
        default: ;
      endcase
    end
  end

  qoa_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (19),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (w_push),
    .din   ({r_ch, w_sample}),
    .pop   (out_ready),
    .dout  (w_fifo_dout),
    .valid (w_fifo_valid),
    .count (w_count)
  );

  assign in_ready   = w_in_ready;
  assign out_valid  = w_fifo_valid;
  assign out_sample = w_fifo_dout[15:0];
  assign out_ch     = w_fifo_dout[18:16];
  assign busy       = (r_state != ST_IDLE);
  assign err        = r_err;

endmodule

// File: tb/tb_qoa_mc_lms_decoder.sv
// tb/tb_qoa_mc_lms_decoder.sv - directed bench for qoa_mc_lms_decoder
module tb_qoa_mc_lms_decoder;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        in_valid  = 1'b0;
  logic [7:0]  in_byte   = 8'h00;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_sample;
  logic [2:0]  out_ch;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int exp_s [5];
  int exp_c [5];

  always #5 sys_clk = ~sys_clk;

  qoa_mc_lms_decoder #(
    .NUM_CH     (2),
    .LMS_LEN    (4),
    .FIFO_DEPTH (4),
    .ACC_W      (36)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_ch     (out_ch),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 64) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 64) check("in_ready_timeout", int'(in_ready), 1);
    @(posedge sys_clk);
    #1 in_valid = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 64) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 64) check("out_valid_timeout", int'(out_valid), 1);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge sys_clk);
    #1 out_ready = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic load(input logic [7:0] hdr, input logic [15:0] val);
    send_byte(hdr);
    send_byte(val[15:8]);
    send_byte(val[7:0]);
  endtask

  task automatic decode(input logic [2:0] ch, input logic [3:0] sf, input logic [2:0] qr);
    send_byte({2'b10, 3'b000, ch});
    send_byte({sf, qr, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_s = '{1, 3, 5, 7, 3};
    exp_c = '{0, 1, 0, 1, 0};

    #12;
    check("rst_in_ready",   int'(in_ready), 1);
    check("rst_out_valid",  int'(out_valid), 0);
    check("rst_out_sample", int'(out_sample), 0);
    check("rst_out_ch",     int'(out_ch), 0);
    check("rst_busy",       int'(busy), 0);
    check("rst_err",        int'(err), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // first decode from zero state, latency T+6
    decode(3'd0, 4'd0, 3'd0);
    check("mac_busy", int'(busy), 1);
    repeat (4) @(negedge sys_clk);
    check("lat_early", int'(out_valid), 0);
    @(negedge sys_clk);
    check("lat_valid", int'(out_valid), 1);
    check("d0_sample", int'($signed(out_sample)), 1);
    check("d0_ch",     int'(out_ch), 0);
    check("d0_hist3",  int'(dut.r_hist[0][3]), 1);
    check("d0_wgt3",   int'(dut.r_wgt[0][3]), 0);
    check("d0_wgt0",   int'(dut.r_wgt[0][0]), 0);
    pop_one();
    check("d0_popped", int'(out_valid), 0);

    // prediction from loaded state on ch1
    load(8'h59, 16'h4000);
    load(8'h19, 16'd1000);
    decode(3'd1, 4'd15, 3'd6);
    wait_out();
    check("d1_sample", int'($signed(out_sample)), 16336);
    check("d1_ch",     int'(out_ch), 1);
    check("d1_wgt0",   int'(dut.r_wgt[1][0]), 896);
    check("d1_wgt2",   int'(dut.r_wgt[1][2]), 896);
    check("d1_wgt3",   int'(dut.r_wgt[1][3]), 17280);
    check("d1_hist3",  int'(dut.r_hist[1][3]), 16336);
    check("d1_hist2",  int'(dut.r_hist[1][2]), 1000);
    check("d1_ch0_hist3", int'(dut.r_hist[0][3]), 1);
    pop_one();

    // positive clamp
    send_byte(8'hC1);
    check("rst_ch1_wgt3",  int'(dut.r_wgt[1][3]), 0);
    check("rst_ch1_hist3", int'(dut.r_hist[1][3]), 0);
    load(8'h59, 16'h4000);
    load(8'h19, 16'h7FFF);
    decode(3'd1, 4'd15, 3'd6);
    wait_out();
    check("clamp_pos", int'($signed(out_sample)), 32767);
    pop_one();

    // negative clamp; delta=-896, hist<0 adds +896, hist=0 adds -896
    send_byte(8'hC1);
    load(8'h59, 16'h4000);
    load(8'h19, 16'h8000);
    decode(3'd1, 4'd15, 3'd7);
    wait_out();
    check("clamp_neg",      int'($signed(out_sample)), -32768);
    check("clamp_neg_wgt3", int'(dut.r_wgt[1][3]), 17280);
    check("clamp_neg_wgt0", int'(dut.r_wgt[1][0]), -896);
    pop_one();
    send_byte(8'hC1);

    // fill the FIFO, fifth payload must stall
    decode(3'd0, 4'd0, 3'd0);
    decode(3'd1, 4'd0, 3'd2);
    decode(3'd0, 4'd0, 3'd4);
    decode(3'd1, 4'd0, 3'd6);
    send_byte({2'b10, 3'b000, 3'd0});
    in_valid = 1'b1;
    in_byte  = {4'd0, 3'd2, 1'b0};
    repeat (3) @(negedge sys_clk);
    check("full_in_ready",  int'(in_ready), 0);
    check("full_busy",      int'(busy), 1);
    check("full_out_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    check("pop_cycle_in_ready", int'(in_ready), 0);
    check("fifo_s0", int'($signed(out_sample)), exp_s[0]);
    check("fifo_c0", int'(out_ch), exp_c[0]);
    @(posedge sys_clk);
    #1 out_ready = 1'b0;
    @(negedge sys_clk);
    check("after_pop_in_ready", int'(in_ready), 1);
    @(posedge sys_clk);
    #1 in_valid = 1'b0;
    @(negedge sys_clk);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      wait_out();
      check("fifo_sample", int'($signed(out_sample)), exp_s[k]);
      check("fifo_ch",     int'(out_ch), exp_c[k]);
      @(negedge sys_clk);
    end
    out_ready = 1'b0;
    check("fifo_drained", int'(out_valid), 0);

    // out-of-range load: consumed, err on final byte, no state change
    send_byte(8'h07);
    send_byte(8'h12);
    check("oor_err_mid", int'(err), 0);
    send_byte(8'h34);
    check("oor_err", int'(err), 1);
    @(negedge sys_clk);
    check("oor_err_clear", int'(err), 0);
    check("oor_busy",      int'(busy), 0);
    check("oor_hist1_0",   int'(dut.r_hist[1][0]), 0);
    check("oor_hist1_3",   int'(dut.r_hist[1][3]), 7);

    send_byte(8'hC1);
    for (int t = 0; t < 4; t++) begin
      check("rst_ch1_hist", int'(dut.r_hist[1][t]), 0);
      check("rst_ch1_wgt",  int'(dut.r_wgt[1][t]), 0);
    end
    check("rst_ch1_keeps_ch0", int'(dut.r_hist[0][3]), 3);

    // reset in MAC cycle 2
    decode(3'd0, 4'd0, 3'd6);
    check("mac1_busy",     int'(busy), 1);
    check("mac1_in_ready", int'(in_ready), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("abort_busy",       int'(busy), 0);
    check("abort_in_ready",   int'(in_ready), 1);
    check("abort_out_valid",  int'(out_valid), 0);
    check("abort_out_sample", int'(out_sample), 0);
    check("abort_out_ch",     int'(out_ch), 0);
    check("abort_err",        int'(err), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (8) @(negedge sys_clk);
    check("abort_no_sample", int'(out_valid), 0);
    decode(3'd0, 4'd0, 3'd0);
    wait_out();
    check("post_sample", int'($signed(out_sample)), 1);
    check("post_ch",     int'(out_ch), 0);
    check("post_hist3",  int'(dut.r_hist[0][3]), 1);
    check("post_hist2",  int'(dut.r_hist[0][2]), 0);
    pop_one();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
